// File: rtl/mm_pkg.sv
// Shared types and constants for the MM request path: FSM states, error tags,
// default bus widths and the saturating counter helper.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    RSP     = 2'd3
  } mm_state_e;

  localparam int MM_ADDR_W = 14;
  localparam int MM_DATA_W = 64;

  // Upper 32 bits of a synthesised read response when no real data exists.
  localparam logic [31:0] MM_ERR_TAG      = 32'hDEAD_BEEF;
  localparam logic [31:0] MM_UNMAPPED_TAG = 32'hDEAD_BEEF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max_v);
    return (v == max_v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mm_req_master_if.sv
// Command, response and MM request bus of mm_req_master.
// Handshake rule for cmd_* and rsp_*: a transfer happens on a rising clk edge
// where valid and ready are both high; a raised valid and its payload stay
// stable until that edge, and ready never depends combinationally on valid.
interface mm_req_master_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_wr;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  logic              oMM_WR_EN;
  logic              oMM_RD_EN;
  logic [ADDR_W-1:0] oMM_ADDR;
  logic [DATA_W-1:0] oMM_WR_DATA;
  logic [DATA_W-1:0] iMM_RD_DATA;
  logic              iMM_RD_DATA_V;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, iMM_RD_DATA, iMM_RD_DATA_V,
    output cmd_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata,
           oMM_WR_EN, oMM_RD_EN, oMM_ADDR, oMM_WR_DATA
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, iMM_RD_DATA, iMM_RD_DATA_V,
    input  cmd_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata,
           oMM_WR_EN, oMM_RD_EN, oMM_ADDR, oMM_WR_DATA
  );
endinterface

// File: rtl/mm_req_master.sv
// Single-outstanding MM request initiator: one command in, one strobe on the
// MM bus, one response out, with a read timeout and stray-data accounting.
module mm_req_master
  import mm_pkg::*;
#(
  parameter int ADDR_W  = MM_ADDR_W,
  parameter int DATA_W  = MM_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  mm_req_master_if.master   bus,
  output logic [15:0]       timeout_cnt,
  output logic [7:0]        stray_cnt,
  output mm_state_e         state_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mm_state_e         state_q, state_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic [7:0]        stray_q, stray_d;
  logic [DATA_W-1:0] err_pat;

  logic accept, rd_hit, rd_to;
  assign accept = (state_q == IDLE) && bus.cmd_valid;
  assign rd_hit = (state_q == WAIT_RD) && bus.iMM_RD_DATA_V;
  // Data arriving on the last wait cycle takes priority over the timeout.
  assign rd_to  = (state_q == WAIT_RD) && !bus.iMM_RD_DATA_V && (wait_cnt_q == CNT_LAST);

  always_comb begin
    err_pat                     = '0;
    err_pat[DATA_W-1 -: 32]     = MM_ERR_TAG;
    err_pat[ADDR_W-1:0]         = addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_wr_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      tcnt_q      <= '0;
      stray_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_wr_q    <= cmd_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      tcnt_q      <= tcnt_d;
      stray_q     <= stray_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     state_d = cmd_wr_q ? RSP : WAIT_RD;
      WAIT_RD: if (rd_hit || rd_to) state_d = RSP;
      RSP:     if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so their next values are derived from state_d.
  always_comb begin
    cmd_wr_d    = cmd_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    tcnt_d      = tcnt_q;
    stray_d     = stray_q;
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    wr_en_d     = accept && bus.cmd_wr;
    rd_en_d     = accept && !bus.cmd_wr;

    if (accept) begin
      cmd_wr_d = bus.cmd_wr;
      addr_d   = bus.cmd_addr;
      wdata_d  = bus.cmd_wdata;
    end

    if (state_q == REQ)          wait_cnt_d = '0;
    else if (state_q == WAIT_RD) wait_cnt_d = wait_cnt_q + CNT_ONE;

    if (state_q == REQ && cmd_wr_q) begin
      rsp_wr_d    = 1'b1;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
    end
    if (rd_hit) begin
      rsp_wr_d    = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = bus.iMM_RD_DATA;
    end
    if (rd_to) begin
      rsp_wr_d    = 1'b0;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = err_pat;
      tcnt_d      = 16'(sat_inc(tcnt_q, 16'hFFFF));
    end
    if (bus.iMM_RD_DATA_V && state_q != WAIT_RD)
      stray_d = 8'(sat_inc({8'h00, stray_q}, 16'h00FF));
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_wr      = rsp_wr_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.oMM_WR_EN   = wr_en_q;
  assign bus.oMM_RD_EN   = rd_en_q;
  assign bus.oMM_ADDR    = addr_q;
  assign bus.oMM_WR_DATA = wdata_q;
  assign timeout_cnt     = tcnt_q;
  assign stray_cnt       = stray_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_mm_req_master.sv
// Directed bench for mm_req_master with TIMEOUT=8: a vector table of single
// transactions plus hand-written backpressure, stray and reset sequences.
module tb_mm_req_master;
  import mm_pkg::*;

  localparam int AW = 14;
  localparam int DW = 64;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] timeout_cnt;
  logic [7:0]  stray_cnt;
  mm_state_e   state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  mm_req_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mm_req_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .timeout_cnt (timeout_cnt),
    .stray_cnt   (stray_cnt),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;        // responder latency after the strobe cycle, 0 = silent
    logic [DW-1:0] rd_in;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_cyc;    // cycles from accept edge to rsp_valid
    logic [15:0]   exp_tcnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk(name, 64'(bus.cmd_ready), 64'd1);
  endtask

  task automatic pulse_stray();
    bus.iMM_RD_DATA   = 64'h5555_AAAA_5555_AAAA;
    bus.iMM_RD_DATA_V = 1'b1;
    step();
    bus.iMM_RD_DATA_V = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    bit seen;
    wait_ready("vec_cmd_ready");
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    step();
    bus.cmd_valid = 1'b0;
    chk("strobe_wr", 64'(bus.oMM_WR_EN), 64'(v.wr));
    chk("strobe_rd", 64'(bus.oMM_RD_EN), 64'(!v.wr));
    chk("mm_addr", 64'(bus.oMM_ADDR), 64'(v.addr));
    if (v.wr) chk("mm_wdata", bus.oMM_WR_DATA, v.wdata);
    chk("busy_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    n = 1;
    seen = 0;
    while (n <= 40 && !seen) begin
      if (n == 2) chk("strobe_one_cycle", 64'({bus.oMM_WR_EN, bus.oMM_RD_EN}), 64'd0);
      if (bus.rsp_valid) seen = 1;
      else begin
        bus.iMM_RD_DATA_V = (v.lat > 0) && (n == 1 + v.lat);
        bus.iMM_RD_DATA   = v.rd_in;
        step();
        n++;
      end
    end
    bus.iMM_RD_DATA_V = 1'b0;
    chk("rsp_seen", 64'(seen), 64'd1);
    chk("rsp_latency", 64'(n), 64'(v.exp_cyc));
    chk("rsp_wr", 64'(bus.rsp_wr), 64'(v.wr));
    chk("rsp_err", 64'(bus.rsp_err), 64'(v.exp_err));
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("timeout_cnt", 64'(timeout_cnt), 64'(v.exp_tcnt));
    chk("stray_cnt_zero", 64'(stray_cnt), 64'd0);
    step();
    chk("rsp_done_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rsp_done_ready", 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 14'h0010, 64'h1122_3344_5566_7788, 0, 64'h0,
                1'b0, 64'h0, 2, 16'd0};
    vecs[1] = '{1'b0, 14'h0400, 64'h0, 4, 64'hCAFE,
                1'b0, 64'hCAFE, 6, 16'd0};
    vecs[2] = '{1'b0, 14'h0400, 64'h0, 0, 64'h0,
                1'b1, 64'hDEAD_BEEF_0000_0400, 2 + TO, 16'd1};
    vecs[3] = '{1'b0, 14'h3FFF, 64'h0, TO, 64'h0123_4567_89AB_CDEF,
                1'b0, 64'h0123_4567_89AB_CDEF, 2 + TO, 16'd1};
    vecs[4] = '{1'b0, 14'h0001, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3, 16'd1};
    vecs[5] = '{1'b1, 14'h3FFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0,
                1'b0, 64'h0, 2, 16'd1};
    vecs[6] = '{1'b0, 14'h2A5A, 64'h0, 0, 64'h0,
                1'b1, 64'hDEAD_BEEF_0000_2A5A, 2 + TO, 16'd2};

    bus.cmd_valid     = 1'b0;
    bus.cmd_wr        = 1'b0;
    bus.cmd_addr      = '0;
    bus.cmd_wdata     = '0;
    bus.rsp_ready     = 1'b1;
    bus.iMM_RD_DATA   = '0;
    bus.iMM_RD_DATA_V = 1'b0;

    // Clock/reset
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_state", 64'(state_o), 64'(IDLE));
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_ctrl", 64'({bus.rsp_valid, bus.rsp_wr, bus.rsp_err, bus.oMM_WR_EN, bus.oMM_RD_EN}), 64'd0);
    chk("rst_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_addr", 64'(bus.oMM_ADDR), 64'd0);
    chk("rst_wdata", bus.oMM_WR_DATA, 64'd0);
    chk("rst_counters", 64'({timeout_cnt, stray_cnt}), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Late data after a timeout is stray and produces no response.
    pulse_stray();
    chk("stray_count", 64'(stray_cnt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("stray_no_rsp", 64'(bus.rsp_valid), 64'd0);
      step();
    end
    chk("stray_hold_addr", 64'(bus.oMM_ADDR), 64'h2A5A);

    // Backpressure with a second command queued behind the response.
    wait_ready("bp_cmd_ready");
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 14'h0123;
    bus.cmd_wdata = 64'hA5A5_0000_0000_0001;
    step();
    bus.cmd_addr  = 14'h0222;
    bus.cmd_wdata = 64'hB6B6_0000_0000_0002;
    begin
      int n = 0;
      while (!bus.rsp_valid && n < 20) begin
        step();
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_fields", 64'({bus.rsp_wr, bus.rsp_err}), 64'b10);
      chk("bp_rdata", bus.rsp_rdata, 64'd0);
      chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      chk("bp_no_strobe", 64'(bus.oMM_WR_EN), 64'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_released_valid", 64'(bus.rsp_valid), 64'd0);
    chk("bp_released_ready", 64'(bus.cmd_ready), 64'd1);
    step();
    bus.cmd_valid = 1'b0;
    chk("bp_queued_strobe", 64'(bus.oMM_WR_EN), 64'd1);
    chk("bp_queued_addr", 64'(bus.oMM_ADDR), 64'h0222);
    chk("bp_queued_wdata", bus.oMM_WR_DATA, 64'hB6B6_0000_0000_0002);
    step();
    chk("bp_queued_rsp", 64'(bus.rsp_valid), 64'd1);
    step();

    // Reset in the middle of a read wait.
    wait_ready("rr_cmd_ready");
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 14'h0055;
    step();
    bus.cmd_valid = 1'b0;
    repeat (3) step();
    chk("rr_in_wait", 64'(state_o), 64'(WAIT_RD));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rr_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rr_counters", 64'({timeout_cnt, stray_cnt}), 64'd0);
    chk("rr_state", 64'(state_o), 64'(IDLE));
    pulse_stray();
    chk("rr_stray", 64'(stray_cnt), 64'd1);
    chk("rr_no_rsp", 64'(bus.rsp_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
